// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the CDB arbiter slice.
//   CDB_SRC_ALU / CDB_SRC_LSB : encoding carried on cdb_src
//   ROB_WIDTH_BIT_DEF         : default rob id width
package cdb_arbiter_pkg;

  localparam int   ROB_WIDTH_BIT_DEF = 4;
  localparam logic CDB_SRC_ALU       = 1'b0;
  localparam logic CDB_SRC_LSB       = 1'b1;

  // The source that did not win last time.
  function automatic logic other_src(input logic src);
    return (src == CDB_SRC_ALU) ? CDB_SRC_LSB : CDB_SRC_ALU;
  endfunction

endpackage

// File: rtl/cdb_arbiter_result_queue.sv
// Small per-source result FIFO (2^DEPTH_BIT entries).
// Ports:
//   clk_in, rst_in : clock, synchronous active-high reset
//   flush          : synchronous empty (RoB mispredict)
//   push/push_data : write one entry at the tail
//   pop            : drop the head entry
//   head_data      : current head (valid when count != 0)
//   count          : number of stored entries
// The caller guarantees no push at full and no pop when empty.
module cdb_arbiter_result_queue #(
  parameter int WIDTH     = 36,
  parameter int DEPTH_BIT = 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 flush,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WIDTH-1:0]     push_data,
  output logic [WIDTH-1:0]     head_data,
  output logic [DEPTH_BIT:0]   count
);

  localparam int DEPTH = 1 << DEPTH_BIT;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [DEPTH_BIT-1:0] rd_ptr;
  logic [DEPTH_BIT-1:0] wr_ptr;

  // Pointers are exactly DEPTH_BIT wide, so they wrap modulo depth for free.
  always_ff @(posedge clk_in) begin
    if (rst_in || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; it is never reset.
  always_ff @(posedge clk_in) begin
    if (push && !(rst_in || flush)) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: shares one CDB write-back port between the
// ALU/RS and the LSB result producers, round-robin, one grant per cycle.
// Ports:
//   clk_in, rst_in, rdy_in, clear_in : clock, sync reset, global pause, flush
//   alu_valid/alu_rob_id/alu_value/alu_ready : ALU result handshake
//   lsb_valid/lsb_rob_id/lsb_value/lsb_ready : LSB result handshake
//   cdb_valid/cdb_rob_id/cdb_value/cdb_src   : registered broadcast
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int ROB_WIDTH_BIT   = ROB_WIDTH_BIT_DEF,
  parameter int QUEUE_DEPTH_BIT = 1
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     clear_in,
  input  logic                     alu_valid,
  input  logic [ROB_WIDTH_BIT-1:0] alu_rob_id,
  input  logic [31:0]              alu_value,
  output logic                     alu_ready,
  input  logic                     lsb_valid,
  input  logic [ROB_WIDTH_BIT-1:0] lsb_rob_id,
  input  logic [31:0]              lsb_value,
  output logic                     lsb_ready,
  output logic                     cdb_valid,
  output logic [ROB_WIDTH_BIT-1:0] cdb_rob_id,
  output logic [31:0]              cdb_value,
  output logic                     cdb_src
);

  localparam int ENT_W = ROB_WIDTH_BIT + 32;
  localparam int DEPTH = 1 << QUEUE_DEPTH_BIT;

  logic [ENT_W-1:0]         alu_head, lsb_head;
  logic [QUEUE_DEPTH_BIT:0] alu_count, lsb_count;
  logic                     alu_xfer, lsb_xfer;
  logic                     alu_nonempty, lsb_nonempty;
  logic                     alu_cand, lsb_cand;
  logic [ENT_W-1:0]         alu_cand_ent, lsb_cand_ent;
  logic                     alu_push, lsb_push, alu_pop, lsb_pop;
  logic                     gnt_vld;
  logic                     gnt_src;
  logic [ENT_W-1:0]         gnt_ent;

  logic                     rr_last;
  logic                     vld_p1;
  logic [ROB_WIDTH_BIT-1:0] rob_id_p1;
  logic [31:0]              value_p1;
  logic                     src_p1;

  // ---- stage p0: handshake, candidate selection, round-robin grant ----
  // Ready looks only at the registered count, so a same-cycle pop at full
  // does not reopen the queue.
  assign alu_ready    = rdy_in && (int'(alu_count) < DEPTH);
  assign lsb_ready    = rdy_in && (int'(lsb_count) < DEPTH);
  assign alu_xfer     = alu_valid && alu_ready;
  assign lsb_xfer     = lsb_valid && lsb_ready;
  assign alu_nonempty = (alu_count != '0);
  assign lsb_nonempty = (lsb_count != '0);

  // An empty queue lets the live input compete directly (bypass).
  assign alu_cand     = alu_nonempty || alu_xfer;
  assign lsb_cand     = lsb_nonempty || lsb_xfer;
  assign alu_cand_ent = alu_nonempty ? alu_head : {alu_rob_id, alu_value};
  assign lsb_cand_ent = lsb_nonempty ? lsb_head : {lsb_rob_id, lsb_value};

  always_comb begin
    gnt_vld = rdy_in && (alu_cand || lsb_cand);
    gnt_src = CDB_SRC_ALU;
    if (alu_cand && lsb_cand) gnt_src = other_src(rr_last);
    else if (lsb_cand)        gnt_src = CDB_SRC_LSB;
  end

  assign gnt_ent  = (gnt_src == CDB_SRC_LSB) ? lsb_cand_ent : alu_cand_ent;

  assign alu_pop  = gnt_vld && (gnt_src == CDB_SRC_ALU) && alu_nonempty;
  assign lsb_pop  = gnt_vld && (gnt_src == CDB_SRC_LSB) && lsb_nonempty;
  // A bypass-granted input goes straight to the bus and is not stored.
  assign alu_push = alu_xfer && !(gnt_vld && (gnt_src == CDB_SRC_ALU) && !alu_nonempty);
  assign lsb_push = lsb_xfer && !(gnt_vld && (gnt_src == CDB_SRC_LSB) && !lsb_nonempty);

  cdb_arbiter_result_queue #(.WIDTH(ENT_W), .DEPTH_BIT(QUEUE_DEPTH_BIT)) u_alu_q (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .flush     (clear_in),
    .push      (alu_push),
    .pop       (alu_pop),
    .push_data ({alu_rob_id, alu_value}),
    .head_data (alu_head),
    .count     (alu_count)
  );

  cdb_arbiter_result_queue #(.WIDTH(ENT_W), .DEPTH_BIT(QUEUE_DEPTH_BIT)) u_lsb_q (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .flush     (clear_in),
    .push      (lsb_push),
    .pop       (lsb_pop),
    .push_data ({lsb_rob_id, lsb_value}),
    .head_data (lsb_head),
    .count     (lsb_count)
  );

  // ---- stage p1: registered broadcast ----
  // rr_last starts at LSB so the ALU wins the first tie after reset/clear.
  always_ff @(posedge clk_in) begin
    if (rst_in || clear_in) begin
      vld_p1    <= 1'b0;
      rob_id_p1 <= '0;
      value_p1  <= '0;
      src_p1    <= CDB_SRC_ALU;
      rr_last   <= CDB_SRC_LSB;
    end else if (rdy_in) begin
      vld_p1 <= gnt_vld;
      if (gnt_vld) begin
        rob_id_p1 <= gnt_ent[ENT_W-1:32];
        value_p1  <= gnt_ent[31:0];
        src_p1    <= gnt_src;
        rr_last   <= gnt_src;
      end else begin
        rob_id_p1 <= '0;
        value_p1  <= '0;
      end
    end
  end

  assign cdb_valid  = vld_p1;
  assign cdb_rob_id = rob_id_p1;
  assign cdb_value  = value_p1;
  assign cdb_src    = src_p1;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_in;
  logic        alu_valid, lsb_valid;
  logic [3:0]  alu_rob_id, lsb_rob_id;
  logic [31:0] alu_value, lsb_value;
  logic        alu_ready, lsb_ready;
  logic        cdb_valid, cdb_src;
  logic [3:0]  cdb_rob_id;
  logic [31:0] cdb_value;

  always #5 clk_in = ~clk_in;

  cdb_arbiter #(.ROB_WIDTH_BIT(4), .QUEUE_DEPTH_BIT(1)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .clear_in   (clear_in),
    .alu_valid  (alu_valid),
    .alu_rob_id (alu_rob_id),
    .alu_value  (alu_value),
    .alu_ready  (alu_ready),
    .lsb_valid  (lsb_valid),
    .lsb_rob_id (lsb_rob_id),
    .lsb_value  (lsb_value),
    .lsb_ready  (lsb_ready),
    .cdb_valid  (cdb_valid),
    .cdb_rob_id (cdb_rob_id),
    .cdb_value  (cdb_value),
    .cdb_src    (cdb_src)
  );

  // Behavioural model: each source is a plain queue of results. Accepted
  // inputs join the back; the granted source loses its front entry.
  typedef struct packed { logic [3:0] id; logic [31:0] val; } ent_t;
  ent_t        qa[$], qb[$];
  logic        m_vld, m_src, m_rr;
  logic [3:0]  m_id;
  logic [31:0] m_val;
  bit          known = 0;
  bit          acc_a, acc_b;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    m_vld = 0; m_id = 0; m_val = 0; m_src = 0; m_rr = 1;
    known = 1;
  endtask

  // One clock: drive inputs, check outputs against the model, advance model.
  task automatic step(input logic r, input logic c, input logic rd,
                      input logic av, input logic [3:0] aid, input logic [31:0] aval,
                      input logic lv, input logic [3:0] lid, input logic [31:0] lval);
    bit   xa, xb;
    int   g;
    ent_t e;
    rst_in = r; clear_in = c; rdy_in = rd;
    alu_valid = av; alu_rob_id = aid; alu_value = aval;
    lsb_valid = lv; lsb_rob_id = lid; lsb_value = lval;
    #1;
    if (known) begin
      chk("alu_ready", alu_ready, rd && qa.size() < 2);
      chk("lsb_ready", lsb_ready, rd && qb.size() < 2);
      chk("cdb_valid", cdb_valid, m_vld);
      chk("cdb_rob_id", cdb_rob_id, m_id);
      chk("cdb_value", cdb_value, m_val);
      if (m_vld) chk("cdb_src", cdb_src, m_src);
    end
    xa = av && rd && qa.size() < 2;
    xb = lv && rd && qb.size() < 2;
    acc_a = xa;
    acc_b = xb;
    if (r || c) begin
      model_reset();
    end else if (rd) begin
      if (xa) begin e.id = aid; e.val = aval; qa.push_back(e); end
      if (xb) begin e.id = lid; e.val = lval; qb.push_back(e); end
      g = -1;
      if (qa.size() > 0 && qb.size() > 0) g = (m_rr == 1'b1) ? 0 : 1;
      else if (qa.size() > 0)             g = 0;
      else if (qb.size() > 0)             g = 1;
      if (g == 0)      e = qa.pop_front();
      else if (g == 1) e = qb.pop_front();
      if (g >= 0) begin
        m_vld = 1; m_id = e.id; m_val = e.val; m_src = (g == 1); m_rr = (g == 1);
      end else begin
        m_vld = 0; m_id = 0; m_val = 0;
      end
    end
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic idle();
    step(0, 0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  bit          pa, pb;
  logic [3:0]  ra_id, rb_id;
  logic [31:0] ra_val, rb_val;
  logic        r_rst, r_clr, r_rdy;

  initial begin
    @(negedge clk_in);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    idle();
    chk("reset_cdb_valid", cdb_valid, 0);
    chk("reset_cdb_value", cdb_value, 0);
    chk("reset_alu_ready", alu_ready, 1);
    chk("reset_lsb_ready", lsb_ready, 1);

    // Single bypassed ALU result: one-cycle latency, one-cycle pulse.
    step(0, 0, 1, 1, 4'd3, 32'h1234, 0, 0, 0);
    chk("t1_valid", cdb_valid, 1);
    chk("t1_id", cdb_rob_id, 3);
    chk("t1_value", cdb_value, 32'h1234);
    chk("t1_src", cdb_src, 0);
    idle();
    chk("t1_pulse_end", cdb_valid, 0);

    // Ties after reset: ALU first, then alternate.
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 4'd1, 32'hA, 1, 4'd2, 32'hB);
    chk("t2_first_id", cdb_rob_id, 1);
    chk("t2_first_src", cdb_src, 0);
    idle();
    chk("t2_second_id", cdb_rob_id, 2);
    chk("t2_second_src", cdb_src, 1);
    idle();
    step(0, 0, 1, 1, 4'd4, 32'h4, 1, 4'd5, 32'h5);
    chk("t2_tie_id", cdb_rob_id, 4);
    idle();
    chk("t2_tie2_id", cdb_rob_id, 5);

    // Clear discards an offered LSB result.
    step(0, 1, 1, 0, 0, 0, 1, 4'd9, 32'h9);
    chk("t4_valid", cdb_valid, 0);
    chk("t4_alu_ready", alu_ready, 1);
    chk("t4_lsb_ready", lsb_ready, 1);
    idle();
    chk("t4_no_id9", cdb_valid, 0);

    // Pause holds the bus and drops ready.
    step(0, 0, 1, 1, 4'd2, 32'h22, 1, 4'd3, 32'h33);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_hold_id", cdb_rob_id, 2);
    chk("t5_hold_valid", cdb_valid, 1);
    chk("t5_ready_low", alu_ready, 0);
    idle();
    chk("t5_resume_id", cdb_rob_id, 3);
    chk("t5_resume_src", cdb_src, 1);

    // Reset and clear together with a result still pending.
    step(0, 0, 1, 1, 4'd6, 32'h66, 1, 4'd7, 32'h77);
    step(1, 1, 1, 1, 4'd8, 32'h88, 1, 4'd9, 32'h99);
    chk("t6_valid", cdb_valid, 0);
    chk("t6_id", cdb_rob_id, 0);
    chk("t6_value", cdb_value, 0);
    step(0, 0, 1, 1, 4'd1, 32'h1, 1, 4'd2, 32'h2);
    chk("t6_tie_src", cdb_src, 0);
    chk("t6_tie_id", cdb_rob_id, 1);

    // Randomized traffic; producers hold an offer until it is accepted.
    pa = 0; pb = 0;
    ra_id = 0; rb_id = 0; ra_val = 0; rb_val = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!pa && $urandom_range(0, 2) != 0) begin
        pa = 1; ra_id = 4'($urandom); ra_val = $urandom;
      end
      if (!pb && $urandom_range(0, 2) != 0) begin
        pb = 1; rb_id = 4'($urandom); rb_val = $urandom;
      end
      r_rst = ($urandom_range(0, 299) == 0);
      r_clr = ($urandom_range(0, 59) == 0);
      r_rdy = ($urandom_range(0, 4) != 0);
      step(r_rst, r_clr, r_rdy, pa, ra_id, ra_val, pb, rb_id, rb_val);
      if (acc_a) pa = 0;
      if (acc_b) pb = 0;
    end
    for (int i = 0; i < 6; i++) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between the two result producers: the ALU/ReservationStation and the LoadStoreBuffer.
- The CDB write-back is consumed by the RoB (ready/value per rob id) and by the RS/LSB for operand wake-up.
- Each source has a small result queue; one result is granted per cycle by round-robin.
- Everything is flushed on the RoB mispredict `clear`.

Parameters:
- ROB_WIDTH_BIT, `ROB_WIDTH_BIT: width of the rob id carried with each result.
- QUEUE_DEPTH_BIT, 1: per-source queue holds 2^QUEUE_DEPTH_BIT entries.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global pause; low freezes all state
- clear_in  input  1  RoB flush (mispredict); synchronous
- alu_valid  input  1  ALU result offered
- alu_rob_id  input  ROB_WIDTH_BIT  rob id of ALU result
- alu_value  input  32  ALU result value
- alu_ready  output  1  ALU result accepted this edge if alu_valid
- lsb_valid  input  1  LSB result offered
- lsb_rob_id  input  ROB_WIDTH_BIT  rob id of LSB result
- lsb_value  input  32  LSB result value
- lsb_ready  output  1  LSB result accepted this edge if lsb_valid
- cdb_valid  output  1  broadcast valid (registered)
- cdb_rob_id  output  ROB_WIDTH_BIT  broadcast rob id (registered)
- cdb_value  output  32  broadcast value (registered)
- cdb_src  output  1  `CDB_SRC_ALU / `CDB_SRC_LSB (registered)

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst_in is synchronous, active-high. Priority: rst_in > clear_in > !rdy_in > normal operation.
- Reset/clear values:
  - cdb_valid=0, cdb_rob_id=0, cdb_value=0, cdb_src=0.
  - Both queues empty; round-robin pointer rr_last=LSB, so ALU wins the first tie.
  - alu_ready and lsb_ready read 1 in the cycle after reset/clear.
- Handshake:
  - src_ready = rdy_in && (count_src < 2^QUEUE_DEPTH_BIT).
  - src_ready depends only on registered count, never combinationally on the grant.
  - A transfer occurs at the edge where src_valid && src_ready. The producer holds valid and data until then.
  - At full, a same-cycle pop does not open the queue; ready is 0 that cycle.
- Candidate per source:
  - Queue non-empty: the candidate is the queue head.
  - Queue empty and a transfer occurring: the candidate is the live input (bypass).
  - Otherwise: no candidate.
- Arbitration:
  - Exactly one candidate: grant it.
  - Both: grant the source != rr_last.
  - rr_last updates to the granted source on every grant.
- Per edge, normal operation:
  - Granted candidate → registered onto cdb_* (cdb_valid=1). Latency is 1 cycle for a bypassed result.
  - The granted queue head is popped.
  - A transferred input that was not bypass-granted is pushed to its queue tail.
  - No grant → cdb_valid=0, cdb_rob_id=0, cdb_value=0.
- Queue ordering:
  - FIFO order is preserved per source. Pointers wrap modulo depth.
  - count updates +1 / -1 / 0 for push-only / pop-only / both.
- cdb_valid is a one-cycle pulse per result; each result is broadcast exactly once.
- rdy_in low:
  - No transfer, pop or push; ready outputs read 0.
  - cdb_* and rr_last are held. Consumers ignore the CDB while rdy_in is low.
- clear_in high at an edge:
  - Queues, counts and cdb_* are reset to the reset values.
  - Any input offered that cycle is discarded, even if src_valid && src_ready.
- Queue overflow/underflow are impossible by construction. Simulation $display error + $finish if a push is attempted at full.

Decomposition:
- const.v additions: `CDB_SRC_ALU (1'b0), `CDB_SRC_LSB (1'b1). Reuses `ROB_WIDTH_BIT.
- Sub-module result_queue, instantiated twice. Parametric FIFO with ports push/pop/flush, head data, count.
- Arbitration and output register live in cdb_arbiter.

Test Plan:
1. After reset, alu_valid with rob_id=3, value=0x00001234 for one cycle, queues empty → next cycle cdb_valid=1, rob_id=3, value=0x1234, src=ALU; following cycle cdb_valid=0.
2. Same cycle, ALU (id=1, 0xA) and LSB (id=2, 0xB) → cycle+1 ALU id1; cycle+2 LSB id2. Repeat tie (id=4, id=5) → ALU id4 first, since rr_last=LSB.
3. Both sources hold valid continuously with incrementing ids 0..7 → grants strictly alternate ALU/LSB; ready drops when a queue holds 2. Every id appears exactly once, in per-source order, with no loss.
4. ALU queue holds ids 6,7, then clear_in=1 with lsb_valid (id=9) offered → next cycle cdb_valid=0, both ready=1; ids 6, 7 and 9 never broadcast.
5. Queues hold ALU id 2 and LSB id 3, rdy_in=0 for 3 cycles → cdb_* frozen and ready=0; after rdy_in=1, the remaining results broadcast in round-robin order.
6. rst_in and clear_in asserted together mid-stream with a pending broadcast → all outputs 0 and queues empty next cycle; first post-reset tie grants ALU.
